// File: rtl/fifo_reader_pkg.sv
// Shared types and helpers for the fifo_reader read-side stream adapter.
//   occ_e     : buffered word count of the two-entry output buffer
//   can_issue : read-issue rule (room for one more word after this cycle's pop)
package fifo_reader_pkg;

  localparam int unsigned OCC_WIDTH = 2;

  typedef enum logic [OCC_WIDTH-1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  // Words held plus word in flight minus word leaving must leave one free slot.
  // Compared as level <= 1 + pop so the subtraction can never underflow.
  function automatic logic can_issue(input logic [OCC_WIDTH-1:0] occ,
                                     input logic inflight,
                                     input logic pop);
    logic [2:0] level;
    level = 3'(occ) + 3'(inflight);
    return level <= (3'(pop) + 3'd1);
  endfunction

endpackage

// File: rtl/fifo_reader_buf.sv
// Two-entry head/tail output buffer for fifo_reader.
// Ports:
//   clk_i, reset_i : clock, synchronous active-high reset
//   push_i         : push_data_i is captured this edge
//   push_data_i    : word arriving from the FIFO read port
//   pop_i          : head word is consumed this edge (only when valid_o)
//   valid_o        : head holds a word (registered)
//   head_o         : head word (registered)
//   occ_o          : buffered words, 0..2 (registered)
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  push_i,
  input  logic [DATA_WIDTH-1:0] push_data_i,
  input  logic                  pop_i,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] head_o,
  output logic [1:0]            occ_o
);

  occ_e                  occ_q, occ_d;
  logic [DATA_WIDTH-1:0] head_q, head_d;
  logic [DATA_WIDTH-1:0] tail_q, tail_d;
  logic                  valid_q, valid_d;

  // State and data registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      occ_q   <= OCC_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      occ_q   <= occ_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
      valid_q <= valid_d;
    end
  end

  // Next occupancy and entry routing.
  always_comb begin
    occ_d  = occ_q;
    head_d = head_q;
    tail_d = tail_q;
    unique case (occ_q)
      OCC_EMPTY: begin
        if (push_i) begin
          occ_d  = OCC_ONE;
          head_d = push_data_i;
        end
      end
      OCC_ONE: begin
        unique case ({push_i, pop_i})
          2'b10: begin
            occ_d  = OCC_TWO;
            tail_d = push_data_i;
          end
          2'b01: occ_d = OCC_EMPTY;
          // Head leaves and the arriving word replaces it in the same edge.
          2'b11: head_d = push_data_i;
          default: ;
        endcase
      end
      OCC_TWO: begin
        if (pop_i) begin
          head_d = tail_q;
          if (push_i) begin
            tail_d = push_data_i;
          end else begin
            occ_d = OCC_ONE;
          end
        end
      end
      default: occ_d = OCC_EMPTY;
    endcase
    valid_d = (occ_d != OCC_EMPTY);
  end

  assign valid_o = valid_q;
  assign head_o  = head_q;
  assign occ_o   = occ_q;

  // The issue rule must never let a word arrive at a full buffer that is not draining.
  a_no_overflow : assert property (@(posedge clk_i) disable iff (reset_i)
    !(push_i && !pop_i && (occ_q == OCC_TWO)));

endmodule

// File: rtl/fifo_reader.sv
// Drains a FIFO read port (one-cycle registered read latency) into a
// valid/ready stream with full throughput, strict ordering and no over-read.
// Ports:
//   clk_i, reset_i   : clock, synchronous active-high reset
//   fifo_empty_i     : FIFO empty flag
//   fifo_read_data_i : FIFO data, valid the cycle after fifo_read_en_o
//   fifo_read_en_o   : FIFO read strobe (combinational)
//   m_valid_o        : stream word available (registered)
//   m_data_o         : stream word, held while stalled (registered)
//   m_ready_i        : downstream accepts when m_valid_o && m_ready_i
//   occupancy_o      : buffered words 0..2
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  fifo_empty_i,
  input  logic [DATA_WIDTH-1:0] fifo_read_data_i,
  output logic                  fifo_read_en_o,
  output logic                  m_valid_o,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  m_ready_i,
  output logic [1:0]            occupancy_o
);

  logic       inflight_q;
  logic       pop;
  logic [1:0] occ;

  assign pop = m_valid_o && m_ready_i;

  // Read issue; the m_ready_i term lets a read go out in the same cycle a word leaves.
  always_comb begin
    fifo_read_en_o = !reset_i && !fifo_empty_i && can_issue(occ, inflight_q, pop);
  end

  // A read issued just before reset is dropped by clearing the in-flight flag.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= fifo_read_en_o;
    end
  end

  fifo_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .push_i      (inflight_q),
    .push_data_i (fifo_read_data_i),
    .pop_i       (pop),
    .valid_o     (m_valid_o),
    .head_o      (m_data_o),
    .occ_o       (occ)
  );

  assign occupancy_o = occ;

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader driven by a behavioural FIFO with a
// one-cycle registered read port.
module tb_fifo_reader;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       fifo_empty = 1'b1;
  logic [7:0] fifo_rd_data = 8'h00;
  logic       read_en;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [1:0] occupancy;

  logic [7:0] fq[$];
  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  // Behavioural FIFO: write lands this edge, read data is registered.
  always @(posedge clk) begin
    if (read_en && fq.size() > 0) fifo_rd_data <= fq.pop_front();
    if (wr_en) fq.push_back(wr_data);
    fifo_empty <= (fq.size() == 0);
  end

  fifo_reader #(.DATA_WIDTH(8)) dut (
    .clk_i            (clk),
    .reset_i          (reset),
    .fifo_empty_i     (fifo_empty),
    .fifo_read_data_i (fifo_rd_data),
    .fifo_read_en_o   (read_en),
    .m_valid_o        (m_valid),
    .m_data_o         (m_data),
    .m_ready_i        (m_ready),
    .occupancy_o      (occupancy)
  );

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      settle();
      tests_run++;
      if (read_en !== 1'b0) begin
        tests_failed++;
        $display("FAIL reset_read_en: got %b expected 0", read_en);
      end
    end
    next_cycle();
    reset = 1'b0;
    settle();
    tests_run++;
    if (m_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_valid: got %b expected 0", m_valid);
    end
    tests_run++;
    if (m_data !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_data: got %h expected 00", m_data);
    end
    tests_run++;
    if (occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_occ: got %0d expected 0", occupancy);
    end
  endtask

  task automatic test_single_word();
    int reads = 0;
    int valids = 0;
    int rd_cyc = -1;
    int v_cyc = -1;
    logic [7:0] vdata = 8'h00;
    m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      wr_en = (c == 0);
      wr_data = 8'hA5;
      settle();
      if (read_en) begin
        reads++;
        if (rd_cyc < 0) rd_cyc = c;
      end
      if (m_valid) begin
        valids++;
        if (v_cyc < 0) begin
          v_cyc = c;
          vdata = m_data;
        end
      end
    end
    tests_run++;
    if (reads != 1 || rd_cyc != 1) begin
      tests_failed++;
      $display("FAIL single_read: got %0d reads at cycle %0d expected 1 at cycle 1", reads, rd_cyc);
    end
    tests_run++;
    if (valids != 1 || v_cyc != 3) begin
      tests_failed++;
      $display("FAIL single_valid: got %0d valid cycles at cycle %0d expected 1 at cycle 3", valids, v_cyc);
    end
    tests_run++;
    if (vdata !== 8'hA5) begin
      tests_failed++;
      $display("FAIL single_data: got %h expected a5", vdata);
    end
    tests_run++;
    if (fifo_empty !== 1'b1 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL single_drained: got empty=%b occ=%0d expected empty=1 occ=0", fifo_empty, occupancy);
    end
  endtask

  task automatic test_burst();
    int viol = 0;
    int n = 0;
    int bad = 0;
    int first = -1;
    int last = -1;
    m_ready = 1'b0;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      wr_en = (c < 16);
      wr_data = 8'(c + 1);
      settle();
      if (read_en && fifo_empty) viol++;
    end
    tests_run++;
    if (occupancy !== 2'd2 || m_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL burst_prefill: got occ=%0d data=%h expected occ=2 data=01", occupancy, m_data);
    end
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      m_ready = 1'b1;
      settle();
      if (read_en && fifo_empty) viol++;
      if (m_valid && m_ready) begin
        if (first < 0) first = c;
        last = c;
        if (m_data !== 8'(n + 1)) bad++;
        n++;
      end
    end
    tests_run++;
    if (n != 16 || first != 0 || last != 15) begin
      tests_failed++;
      $display("FAIL burst_throughput: got %0d words in cycles %0d..%0d expected 16 in 0..15", n, first, last);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL burst_order: got %0d out-of-order words expected 0", bad);
    end
    tests_run++;
    if (viol != 0) begin
      tests_failed++;
      $display("FAIL burst_empty_read: got %0d reads while empty expected 0", viol);
    end
  endtask

  task automatic test_backpressure();
    int reads = 0;
    int n = 0;
    int bad = 0;
    m_ready = 1'b0;
    for (int c = 0; c < 12; c++) begin
      next_cycle();
      wr_en = (c < 5);
      wr_data = 8'(c + 1);
      settle();
      if (read_en) reads++;
    end
    tests_run++;
    if (reads != 2) begin
      tests_failed++;
      $display("FAIL bp_reads: got %0d expected 2", reads);
    end
    tests_run++;
    if (occupancy !== 2'd2 || m_valid !== 1'b1 || m_data !== 8'h01) begin
      tests_failed++;
      $display("FAIL bp_hold: got occ=%0d valid=%b data=%h expected occ=2 valid=1 data=01", occupancy, m_valid, m_data);
    end
    tests_run++;
    if (fifo_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_fifo_left: got empty=%b expected 0", fifo_empty);
    end
    for (int c = 0; c < 30; c++) begin
      next_cycle();
      m_ready = (c % 2 == 0);
      settle();
      if (m_valid && m_ready) begin
        if (m_data !== 8'(n + 1)) bad++;
        n++;
      end
    end
    tests_run++;
    if (n != 5 || bad != 0) begin
      tests_failed++;
      $display("FAIL bp_drain: got %0d words with %0d misordered expected 5 with 0", n, bad);
    end
  endtask

  task automatic test_simultaneous();
    int n = 0;
    int bad = 0;
    int occbad = 0;
    int first = -1;
    int last = -1;
    m_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      next_cycle();
      wr_en = (c < 12);
      wr_data = 8'(32'h20 + c);
      settle();
      if (m_valid) begin
        if (first < 0) first = c;
        last = c;
        if (occupancy !== 2'd1) occbad++;
        if (m_data !== 8'(32'h20 + n)) bad++;
        n++;
      end
    end
    tests_run++;
    if (n != 12 || first != 3 || last != 14) begin
      tests_failed++;
      $display("FAIL simul_stream: got %0d words in cycles %0d..%0d expected 12 in 3..14", n, first, last);
    end
    tests_run++;
    if (occbad != 0) begin
      tests_failed++;
      $display("FAIL simul_occ: got %0d cycles with occ!=1 expected 0", occbad);
    end
    tests_run++;
    if (bad != 0) begin
      tests_failed++;
      $display("FAIL simul_data: got %0d wrong words expected 0", bad);
    end
  endtask

  task automatic test_reset_mid();
    int leaks = 0;
    int n = 0;
    logic [7:0] got = 8'h00;
    m_ready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      wr_en = (c < 3);
      wr_data = 8'(32'h30 + c);
      settle();
    end
    tests_run++;
    if (occupancy !== 2'd2 || fifo_empty !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_setup: got occ=%0d empty=%b expected occ=2 empty=0", occupancy, fifo_empty);
    end
    next_cycle();
    m_ready = 1'b1;
    settle();
    tests_run++;
    if (read_en !== 1'b1 || m_data !== 8'h30) begin
      tests_failed++;
      $display("FAIL mid_issue: got read_en=%b data=%h expected read_en=1 data=30", read_en, m_data);
    end
    next_cycle();
    m_ready = 1'b0;
    reset = 1'b1;
    settle();
    tests_run++;
    if (read_en !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_reset_read_en: got %b expected 0", read_en);
    end
    next_cycle();
    reset = 1'b0;
    settle();
    tests_run++;
    if (m_valid !== 1'b0 || occupancy !== 2'd0) begin
      tests_failed++;
      $display("FAIL mid_cleared: got valid=%b occ=%0d expected valid=0 occ=0", m_valid, occupancy);
    end
    m_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      next_cycle();
      settle();
      if (m_valid) leaks++;
    end
    tests_run++;
    if (leaks != 0 || fifo_empty !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_no_leak: got %0d valid cycles empty=%b expected 0 valid empty=1", leaks, fifo_empty);
    end
    for (int c = 0; c < 10; c++) begin
      next_cycle();
      wr_en = (c == 0);
      wr_data = 8'h3A;
      settle();
      if (m_valid && m_ready) begin
        n++;
        got = m_data;
      end
    end
    tests_run++;
    if (n != 1 || got !== 8'h3A) begin
      tests_failed++;
      $display("FAIL mid_recover: got %0d words last=%h expected 1 word 3a", n, got);
    end
  endtask

  task automatic test_empty_guard();
    int reads = 0;
    int valids = 0;
    for (int c = 0; c < 100; c++) begin
      next_cycle();
      wr_en = 1'b0;
      m_ready = 1'($urandom_range(0, 1));
      settle();
      if (read_en) reads++;
      if (m_valid) valids++;
    end
    tests_run++;
    if (reads != 0) begin
      tests_failed++;
      $display("FAIL guard_read_en: got %0d reads expected 0", reads);
    end
    tests_run++;
    if (valids != 0) begin
      tests_failed++;
      $display("FAIL guard_valid: got %0d valid cycles expected 0", valids);
    end
  endtask

  initial begin
    reset = 1'b1;
    wr_en = 1'b0;
    wr_data = 8'h00;
    m_ready = 1'b0;
    test_reset();
    test_single_word();
    test_burst();
    test_backpressure();
    test_simultaneous();
    test_reset_mid();
    test_empty_guard();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
